// File: rtl/bus_arbiter_nch.sv
// N-channel bus arbiter: fixed-priority or round-robin grant onto one
// bus master port, with optional per-transaction ack timeout.
module bus_arbiter_nch #(
   parameter int XLEN     = 32,
   parameter int N_CH     = 2,
   parameter int ARB_MODE = 0,
   parameter int TIMEOUT  = 0,
   localparam int GW      = $clog2(N_CH)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [N_CH-1:0]   i_req,
   input  logic [N_CH-1:0]   i_wr_en,
   input  logic [N_CH*XLEN-1:0] i_addr,
   input  logic [N_CH*XLEN-1:0] i_wr_data,
   input  logic [N_CH*4-1:0] i_byte_en,
   output logic [N_CH-1:0]   o_ack,
   output logic [N_CH-1:0]   o_err,
   output logic [XLEN-1:0]   o_rd_data,
   output logic [GW-1:0]     o_grant,
   output logic              o_busy,
   output logic              o_bus_en,
   output logic              o_wr_en,
   output logic [XLEN-1:0]   o_addr,
   output logic [XLEN-1:0]   o_wr_data,
   output logic [3:0]        o_byte_en,
   input  logic              i_ack,
   input  logic [XLEN-1:0]   i_rd_data
);

   localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int TO_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CW-1:0] TO_LAST = CW'(TO_M1);
   localparam logic [GW-1:0] CH_MAX  = GW'(N_CH - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t state_q, state_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [GW-1:0] last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wr_q, wr_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [3:0]    be_q, be_d;

   logic [XLEN-1:0] ch_addr  [N_CH];
   logic [XLEN-1:0] ch_wdata [N_CH];
   logic [3:0]      ch_be    [N_CH];

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      assign ch_addr[g]  = i_addr[g*XLEN +: XLEN];
      assign ch_wdata[g] = i_wr_data[g*XLEN +: XLEN];
      assign ch_be[g]    = i_byte_en[g*4 +: 4];
   end

   logic [GW-1:0]   k;
   logic [GW-1:0]   win;
   logic            found;
   logic            busy;
   logic            to_hit;
   logic [N_CH-1:0] grant_oh;

   assign busy   = (state_q == BUSY);
   assign to_hit = (TIMEOUT > 0) && (cnt_q == TO_LAST) && !i_ack;

   // Fixed priority is a round-robin scan that always starts after CH_MAX.
   always_comb begin
      k     = (ARB_MODE == 1) ? last_q : CH_MAX;
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         k = (k == CH_MAX) ? '0 : k + 1'b1;
         if (!found && i_req[k]) begin
            win   = k;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d = BUSY;
               grant_d = win;
               last_d  = win;
               cnt_d   = '0;
               wr_d    = i_wr_en[win];
               addr_d  = ch_addr[win];
               wdata_d = ch_wdata[win];
               be_d    = ch_be[win];
            end
         end
         BUSY: begin
            if (i_ack || to_hit) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= CH_MAX;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
      end
   end

   always_comb begin
      grant_oh          = '0;
      grant_oh[grant_q] = 1'b1;
   end

   assign o_ack     = (busy && i_ack) ? grant_oh : '0;
   assign o_err     = (busy && to_hit) ? grant_oh : '0;
   assign o_rd_data = i_rd_data;
   assign o_grant   = grant_q;
   assign o_busy    = busy;
   assign o_bus_en  = busy;
   assign o_wr_en   = wr_q;
   assign o_addr    = addr_q;
   assign o_wr_data = wdata_q;
   assign o_byte_en = be_q;

endmodule

// File: tb/tb_bus_arbiter_nch.sv
// Bench for bus_arbiter_nch: a 2-channel fixed/timeout instance and a
// 4-channel round-robin instance, checked against a grant scoreboard.
module tb_bus_arbiter_nch;

   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 2-channel, fixed priority, TIMEOUT=8
   logic [1:0]  f_req, f_wr_en, f_ack, f_err;
   logic [63:0] f_addr, f_wdata;
   logic [7:0]  f_be;
   logic [31:0] f_rdata, f_baddr, f_bwdata, f_irdata;
   logic [0:0]  f_grant;
   logic        f_busy, f_bus_en, f_bwr, f_iack;
   logic [3:0]  f_bbe;

   bus_arbiter_nch #(.XLEN(32), .N_CH(2), .ARB_MODE(0), .TIMEOUT(8)) u_fix (
      .i_clk(clk), .i_rst(rst),
      .i_req(f_req), .i_wr_en(f_wr_en),
      .i_addr(f_addr), .i_wr_data(f_wdata), .i_byte_en(f_be),
      .o_ack(f_ack), .o_err(f_err), .o_rd_data(f_rdata),
      .o_grant(f_grant), .o_busy(f_busy), .o_bus_en(f_bus_en),
      .o_wr_en(f_bwr), .o_addr(f_baddr), .o_wr_data(f_bwdata),
      .o_byte_en(f_bbe), .i_ack(f_iack), .i_rd_data(f_irdata)
   );

   // 4-channel, round-robin, no timeout
   logic [3:0]   r_req, r_wr_en, r_ack, r_err;
   logic [127:0] r_addr, r_wdata;
   logic [15:0]  r_be;
   logic [31:0]  r_rdata, r_baddr, r_bwdata, r_irdata;
   logic [1:0]   r_grant;
   logic         r_busy, r_bus_en, r_bwr, r_iack;
   logic [3:0]   r_bbe;

   bus_arbiter_nch #(.XLEN(32), .N_CH(4), .ARB_MODE(1), .TIMEOUT(0)) u_rr (
      .i_clk(clk), .i_rst(rst),
      .i_req(r_req), .i_wr_en(r_wr_en),
      .i_addr(r_addr), .i_wr_data(r_wdata), .i_byte_en(r_be),
      .o_ack(r_ack), .o_err(r_err), .o_rd_data(r_rdata),
      .o_grant(r_grant), .o_busy(r_busy), .o_bus_en(r_bus_en),
      .o_wr_en(r_bwr), .o_addr(r_baddr), .o_wr_data(r_bwdata),
      .o_byte_en(r_bbe), .i_ack(r_iack), .i_rd_data(r_irdata)
   );

   typedef struct {
      int          g;
      logic [31:0] a;
   } exp_t;

   exp_t sb_f[$];
   exp_t sb_r[$];
   int   total = 0;
   int   bad   = 0;
   int   rr_last = 3;
   logic [3:0] plan [8];

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_next(input int last, input logic [3:0] req);
      for (int i = 1; i <= 4; i++) begin
         if (req[(last + i) % 4]) return (last + i) % 4;
      end
      return -1;
   endfunction

   function automatic logic [31:0] r_ch_addr(input int c);
      return 32'h0000_1000 * (c + 1);
   endfunction

   task automatic pop_f(output exp_t e);
      e.g = -1;
      e.a = '0;
      if (sb_f.size() > 0) e = sb_f.pop_front();
   endtask

   task automatic push_r(input logic [3:0] req);
      exp_t e;
      int   g;
      g = rr_next(rr_last, req);
      if (g >= 0) begin
         e.g = g;
         e.a = r_ch_addr(g);
         sb_r.push_back(e);
         rr_last = g;
      end
   endtask

   // Wait for a grant, check it against the scoreboard, ack one cycle later
   task automatic serve_r(input logic [3:0] next_req);
      exp_t e;
      int   n;
      n = 0;
      while (r_bus_en !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("rr grant arrives", 64'(n < 10), 64'd1);
      e.g = -1;
      e.a = '0;
      if (sb_r.size() > 0) e = sb_r.pop_front();
      chk("rr grant idx", 64'(r_grant), 64'(e.g));
      chk("rr bus addr", 64'(r_baddr), 64'(e.a));
      @(negedge clk);
      r_iack = 1'b1;
      r_req  = next_req;
      push_r(next_req);
      #1;
      chk("rr ack onehot", 64'(r_ack), 64'(4'b0001 << e.g));
      chk("rr no err", 64'(r_err), 64'd0);
      @(negedge clk);
      r_iack = 1'b0;
      chk("rr idle gap", 64'(r_bus_en), 64'd0);
   endtask

   initial begin
      exp_t e;
      rst = 1'b0;
      f_req = '0; f_wr_en = '0; f_addr = '0; f_wdata = '0; f_be = '0;
      f_iack = 1'b0; f_irdata = '0;
      r_req = '0; r_wr_en = '0; r_wdata = '0; r_be = '0;
      r_iack = 1'b0; r_irdata = '0;
      for (int c = 0; c < 4; c++) r_addr[c*32 +: 32] = r_ch_addr(c);
      plan = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h5, 4'h3, 4'h0};

      repeat (3) @(negedge clk);
      chk("rst bus_en", 64'(f_bus_en), 64'd0);
      chk("rst busy", 64'(f_busy), 64'd0);
      chk("rst grant", 64'(f_grant), 64'd0);
      chk("rst bus fields", {f_bwr, f_bbe, f_baddr}, 64'd0);
      chk("rst wdata", 64'(f_bwdata), 64'd0);
      chk("rst rr bus_en", 64'(r_bus_en), 64'd0);

      // Both channels request together: ch0 write, ch1 read
      rst     = 1'b1;
      f_wr_en = 2'b01;
      f_addr  = {32'h0000_1000, 32'h0000_0100};
      f_wdata = {32'h0, 32'hA5A5_A5A5};
      f_be    = {4'hF, 4'b0011};
      f_req   = 2'b11;
      sb_f.push_back('{0, 32'h0000_0100});
      sb_f.push_back('{1, 32'h0000_1000});
      @(negedge clk);
      chk("latency bus_en", 64'(f_bus_en), 64'd1);
      pop_f(e);
      chk("fix grant first", 64'(f_grant), 64'(e.g));
      chk("fix addr first", 64'(f_baddr), 64'(e.a));
      chk("write wr_en", 64'(f_bwr), 64'd1);
      chk("write wdata", 64'(f_bwdata), 64'hA5A5_A5A5);
      chk("write byte_en", 64'(f_bbe), 64'h3);
      repeat (2) begin
         @(negedge clk);
         chk("hold addr", 64'(f_baddr), 64'h100);
         chk("hold wdata", 64'(f_bwdata), 64'hA5A5_A5A5);
         chk("hold no ack", 64'(f_ack), 64'd0);
      end
      f_iack = 1'b1;
      f_req  = 2'b10;
      #1;
      chk("write ack", 64'(f_ack), 64'b01);
      chk("write no err", 64'(f_err), 64'd0);
      @(negedge clk);
      f_iack = 1'b0;
      chk("gap bus_en", 64'(f_bus_en), 64'd0);
      @(negedge clk);
      pop_f(e);
      chk("second bus_en", 64'(f_bus_en), 64'd1);
      chk("fix grant second", 64'(f_grant), 64'(e.g));
      chk("fix addr second", 64'(f_baddr), 64'(e.a));
      chk("read wr_en", 64'(f_bwr), 64'd0);
      f_iack   = 1'b1;
      f_irdata = 32'hDEAD_BEEF;
      f_req    = 2'b00;
      #1;
      chk("read ack", 64'(f_ack), 64'b10);
      chk("read data", 64'(f_rdata), 64'hDEAD_BEEF);
      @(negedge clk);
      f_iack = 1'b0;
      chk("read done busy", 64'(f_busy), 64'd0);

      // Timeout: no ack, error pulse in the eighth busy cycle
      f_req = 2'b10;
      sb_f.push_back('{1, 32'h0000_1000});
      @(negedge clk);
      pop_f(e);
      chk("to grant", 64'(f_grant), 64'(e.g));
      chk("to bus_en", 64'(f_bus_en), 64'd1);
      repeat (6) @(negedge clk);
      chk("to err early", 64'(f_err), 64'd0);
      @(negedge clk);
      chk("to err pulse", 64'(f_err), 64'b10);
      chk("to no ack", 64'(f_ack), 64'd0);
      f_req = 2'b00;
      @(negedge clk);
      chk("to bus_en drop", 64'(f_bus_en), 64'd0);
      chk("to err once", 64'(f_err), 64'd0);

      // Ack in the eighth cycle beats the timeout
      f_req = 2'b01;
      sb_f.push_back('{0, 32'h0000_0100});
      @(negedge clk);
      pop_f(e);
      chk("ack8 grant", 64'(f_grant), 64'(e.g));
      repeat (7) @(negedge clk);
      f_iack = 1'b1;
      f_req  = 2'b00;
      #1;
      chk("ack8 ack", 64'(f_ack), 64'b01);
      chk("ack8 no err", 64'(f_err), 64'd0);
      @(negedge clk);
      f_iack = 1'b0;
      chk("ack8 bus_en drop", 64'(f_bus_en), 64'd0);

      // Reset in the middle of a transaction
      f_req = 2'b10;
      @(negedge clk);
      chk("mid bus_en", 64'(f_bus_en), 64'd1);
      rst   = 1'b0;
      f_req = 2'b00;
      @(negedge clk);
      chk("mid rst bus_en", 64'(f_bus_en), 64'd0);
      chk("mid rst busy", 64'(f_busy), 64'd0);
      chk("mid rst grant", 64'(f_grant), 64'd0);
      chk("mid rst addr", 64'(f_baddr), 64'd0);
      rst    = 1'b1;
      f_iack = 1'b1;
      #1;
      chk("stray ack", 64'(f_ack), 64'd0);
      chk("stray err", 64'(f_err), 64'd0);
      @(negedge clk);
      f_iack = 1'b0;
      chk("stray bus_en", 64'(f_bus_en), 64'd0);

      // Round-robin: rotation, then sparse requests with wrap-around
      r_req = plan[0];
      push_r(plan[0]);
      for (int s = 0; s < 7; s++) serve_r(plan[s+1]);
      @(negedge clk);
      chk("rr final idle", 64'(r_bus_en), 64'd0);
      chk("rr sb empty", 64'(sb_r.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
